unidade_controle: RTL

- Multi-cycle fetch/decode/control FSM for the nRISC core. It sits directly upstream of the register bank (`registradores`).
- Fetches 16-bit instructions through a valid handshake and holds the decoded register/bool addresses stable for the bank.
- Drives ALU op, immediate, write enables, branch/jump PC update and Halt.

---
 rtl/nrisc_pkg.sv | 52 +++++
 rtl/decodificador_instr.sv | 62 ++++++
 rtl/unidade_controle.sv | 123 ++++++++++++
 3 files changed

// File: rtl/nrisc_pkg.sv
// Shared nRISC definitions: opcodes, ALU op codes, control FSM states and
// instruction field positions.
package nrisc_pkg;

    // Opcodes (instruction bits [15:12]); 0xA..0xE are undefined.
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_CMPEQ = 4'h5;
    localparam logic [3:0] OP_CMPLT = 4'h6;
    localparam logic [3:0] OP_LI    = 4'h7;
    localparam logic [3:0] OP_JMP   = 4'h8;
    localparam logic [3:0] OP_BRT   = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // ALU operation codes driven on OpULA.
    localparam logic [2:0] ULA_PASSB = 3'd0;
    localparam logic [2:0] ULA_ADD   = 3'd1;
    localparam logic [2:0] ULA_SUB   = 3'd2;
    localparam logic [2:0] ULA_AND   = 3'd3;
    localparam logic [2:0] ULA_OR    = 3'd4;
    localparam logic [2:0] ULA_EQ    = 3'd5;
    localparam logic [2:0] ULA_LT    = 3'd6;

    // Control FSM states.
    typedef enum logic [2:0] {
        EST_BUSCA      = 3'd0,
        EST_DECODIFICA = 3'd1,
        EST_EXECUTA    = 3'd2,
        EST_ESCRITA    = 3'd3,
        EST_PARADO     = 3'd4
    } estado_t;

    // Instruction field bit positions.
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS1_MSB = 8;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 3;
    localparam int BD_MSB  = 2;
    localparam int BD_LSB  = 1;
    localparam int BS_MSB  = 11;
    localparam int BS_LSB  = 10;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

endpackage

// File: rtl/decodificador_instr.sv
// Combinational decoder: instruction register -> register/bool addresses,
// ALU control and the write/PC intent of the instruction. Timing of the
// actual strobes is left to the control FSM.
module decodificador_instr
    import nrisc_pkg::*;
(
    input  logic [15:0] ir_i,
    output logic [2:0]  reg_lido1_o,
    output logic [2:0]  reg_lido2_o,
    output logic [2:0]  reg_escrito_o,
    output logic [1:0]  bool_lido1_o,
    output logic [1:0]  bool_escrito_o,
    output logic [2:0]  op_ula_o,
    output logic [7:0]  imediato_o,
    output logic        usa_imediato_o,
    output logic        escreve_reg_o,
    output logic        escreve_bool_o,
    output logic        eh_jmp_o,
    output logic        eh_brt_o,
    output logic        eh_halt_o,
    output logic        ilegal_o
);

    logic [3:0] op;

    // Address fields are passed through raw; the bank only acts on them
    // when the FSM raises a write enable.
    assign op             = ir_i[OP_MSB:OP_LSB];
    assign reg_escrito_o  = ir_i[RD_MSB:RD_LSB];
    assign reg_lido1_o    = ir_i[RS1_MSB:RS1_LSB];
    assign reg_lido2_o    = ir_i[RS2_MSB:RS2_LSB];
    assign bool_escrito_o = ir_i[BD_MSB:BD_LSB];
    assign bool_lido1_o   = ir_i[BS_MSB:BS_LSB];
    assign imediato_o     = ir_i[IMM_MSB:IMM_LSB];

    // Opcode -> ALU control and intent flags.
    always_comb begin
        op_ula_o       = ULA_PASSB;
        usa_imediato_o = 1'b0;
        escreve_reg_o  = 1'b0;
        escreve_bool_o = 1'b0;
        eh_jmp_o       = 1'b0;
        eh_brt_o       = 1'b0;
        eh_halt_o      = 1'b0;
        ilegal_o       = 1'b0;
        case (op)
            OP_NOP:   ;
            OP_ADD:   begin op_ula_o = ULA_ADD; escreve_reg_o = 1'b1; end
            OP_SUB:   begin op_ula_o = ULA_SUB; escreve_reg_o = 1'b1; end
            OP_AND:   begin op_ula_o = ULA_AND; escreve_reg_o = 1'b1; end
            OP_OR:    begin op_ula_o = ULA_OR;  escreve_reg_o = 1'b1; end
            OP_CMPEQ: begin op_ula_o = ULA_EQ;  escreve_bool_o = 1'b1; end
            OP_CMPLT: begin op_ula_o = ULA_LT;  escreve_bool_o = 1'b1; end
            OP_LI:    begin op_ula_o = ULA_PASSB; usa_imediato_o = 1'b1; escreve_reg_o = 1'b1; end
            OP_JMP:   eh_jmp_o = 1'b1;
            OP_BRT:   eh_brt_o = 1'b1;
            OP_HALT:  eh_halt_o = 1'b1;
            default:  ilegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/unidade_controle.sv
// nRISC multi-cycle control unit: fetch, decode, execute and write-back FSM
// with program counter and branch/jump resolution.
//
// Fetch handshake: BuscaReq is high only in BUSCA and PC is held stable while
// it is high. An instruction is accepted on the rising edge where both
// BuscaReq and InstrValida are high; InstrValida at any other time is ignored.
module unidade_controle
    import nrisc_pkg::*;
#(
    parameter int                    LARGURA_PC = 8,
    parameter logic [LARGURA_PC-1:0] PC_INICIAL = '0
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic [15:0]           Instrucao,
    input  logic                  InstrValida,
    output logic                  BuscaReq,
    output logic [LARGURA_PC-1:0] PC,
    output logic [2:0]            RegLido1,
    output logic [2:0]            RegLido2,
    output logic [2:0]            RegEscrito,
    output logic                  EscreveReg,
    output logic [1:0]            BoolLido1,
    output logic [1:0]            BoolEscrito,
    output logic                  EscreveBool,
    input  logic                  DadoBool1,
    output logic [2:0]            OpULA,
    output logic [7:0]            Imediato,
    output logic                  UsaImediato,
    output logic                  Halt,
    output logic                  Ilegal,
    output logic [2:0]            EstadoDbg
);

    estado_t               estado_q, estado_d;
    logic [15:0]           ir_q, ir_d;
    logic [LARGURA_PC-1:0] pc_q, pc_d;
    logic [LARGURA_PC-1:0] pc_prox_q, pc_prox_d;

    logic                  dec_escreve_reg, dec_escreve_bool;
    logic                  dec_jmp, dec_brt, dec_halt, dec_ilegal;
    logic [LARGURA_PC-1:0] pc_mais_1, pc_alvo;

    // Decoded fields come straight from IR, so they stay stable from
    // DECODIFICA until the next accepted fetch; IR=0 after reset gives zeros.
    decodificador_instr u_dec (
        .ir_i           (ir_q),
        .reg_lido1_o    (RegLido1),
        .reg_lido2_o    (RegLido2),
        .reg_escrito_o  (RegEscrito),
        .bool_lido1_o   (BoolLido1),
        .bool_escrito_o (BoolEscrito),
        .op_ula_o       (OpULA),
        .imediato_o     (Imediato),
        .usa_imediato_o (UsaImediato),
        .escreve_reg_o  (dec_escreve_reg),
        .escreve_bool_o (dec_escreve_bool),
        .eh_jmp_o       (dec_jmp),
        .eh_brt_o       (dec_brt),
        .eh_halt_o      (dec_halt),
        .ilegal_o       (dec_ilegal)
    );

    // PC wraps naturally at LARGURA_PC bits; imm8 is zero-extended or truncated.
    assign pc_mais_1 = pc_q + LARGURA_PC'(1);
    assign pc_alvo   = LARGURA_PC'(Imediato);
    assign PC        = pc_q;
    assign EstadoDbg = estado_q;

    // State, IR and PC registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            estado_q  <= EST_BUSCA;
            ir_q      <= '0;
            pc_q      <= PC_INICIAL;
            pc_prox_q <= PC_INICIAL;
        end else begin
            estado_q  <= estado_d;
            ir_q      <= ir_d;
            pc_q      <= pc_d;
            pc_prox_q <= pc_prox_d;
        end
    end

    // Next-state logic and per-state strobes.
    always_comb begin
        estado_d    = estado_q;
        ir_d        = ir_q;
        pc_d        = pc_q;
        pc_prox_d   = pc_prox_q;
        BuscaReq    = 1'b0;
        EscreveReg  = 1'b0;
        EscreveBool = 1'b0;
        Ilegal      = 1'b0;
        Halt        = 1'b0;
        case (estado_q)
            EST_BUSCA: begin
                BuscaReq = 1'b1;
                if (InstrValida) begin
                    ir_d     = Instrucao;
                    estado_d = EST_DECODIFICA;
                end
            end
            EST_DECODIFICA: estado_d = EST_EXECUTA;
            EST_EXECUTA: begin
                // Branch condition is sampled here, one cycle after the bool
                // read address became valid.
                Ilegal    = dec_ilegal;
                pc_prox_d = (dec_jmp || (dec_brt && DadoBool1)) ? pc_alvo : pc_mais_1;
                estado_d  = EST_ESCRITA;
            end
            EST_ESCRITA: begin
                EscreveReg  = dec_escreve_reg;
                EscreveBool = dec_escreve_bool;
                pc_d        = pc_prox_q;
                estado_d    = dec_halt ? EST_PARADO : EST_BUSCA;
            end
            EST_PARADO: Halt = 1'b1;
            default:    estado_d = EST_BUSCA;
        endcase
    end

endmodule
